// File: rtl/lc3_pkg.sv
// lc3_pkg: shared LC-3 widths, condition-code encoding and CC derivation helper.
package lc3_pkg;
  localparam int WORD_W = 16;
  localparam int REG_ADDR_W = 3;
  typedef logic [2:0] cc_t;
  localparam cc_t CC_N = 3'b100;
  localparam cc_t CC_Z = 3'b010;
  localparam cc_t CC_P = 3'b001;
  function automatic cc_t cc_from_word(input logic [WORD_W-1:0] word);
    return word[WORD_W-1] ? CC_N : ~|word ? CC_Z : CC_P;
  endfunction
endpackage

// File: rtl/lc3_word_reg.sv
// lc3_word_reg: WIDTH-bit register with write enable and synchronous reset to 0.
module lc3_word_reg #(
  parameter int WIDTH = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             WE,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q
);
  always_ff @(posedge Clk)
    if (Reset) Q <= '0;
    else if (WE) Q <= D;
endmodule

// File: rtl/lc3_regfile.sv
// lc3_regfile: LC-3 register file, 1 write / 2 read ports plus N/Z/P register.
// Optional write-through forwarding when REGFILE_BYPASS_EN is defined.
module lc3_regfile
  import lc3_pkg::*;
#(
  parameter int WIDTH  = WORD_W,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = REG_ADDR_W
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              WE,
  input  logic [ADDR_W-1:0] DR,
  input  logic [WIDTH-1:0]  D,
  input  logic              LD_CC,
  input  logic [ADDR_W-1:0] SR1,
  input  logic [ADDR_W-1:0] SR2,
  output logic [WIDTH-1:0]  SR1_out,
  output logic [WIDTH-1:0]  SR2_out,
  output logic [2:0]        NZP
);
  logic [WIDTH-1:0] q [DEPTH];
  logic dr_ok, sr1_ok, sr2_ok, fwd1, fwd2;
  cc_t cc, cc_next;
  assign dr_ok  = 32'(DR) < DEPTH;
  assign sr1_ok = 32'(SR1) < DEPTH;
  assign sr2_ok = 32'(SR2) < DEPTH;
  genvar i;
  generate
    for (i = 0; i < DEPTH; i++) begin : g_reg
      lc3_word_reg #(.WIDTH(WIDTH)) u_reg (
        .Clk  (Clk),
        .Reset(Reset),
        .WE   (WE && dr_ok && DR == ADDR_W'(i)),
        .D    (D),
        .Q    (q[i])
      );
    end
  endgenerate
`ifdef REGFILE_BYPASS_EN
  assign fwd1 = WE && !Reset && dr_ok && SR1 == DR;
  assign fwd2 = WE && !Reset && dr_ok && SR2 == DR;
`else
  assign fwd1 = 1'b0;
  assign fwd2 = 1'b0;
`endif
  assign SR1_out = fwd1 ? D : sr1_ok ? q[SR1] : '0;
  assign SR2_out = fwd2 ? D : sr2_ok ? q[SR2] : '0;
  // D is treated as signed: sign bit wins, then zero, else positive
  assign cc_next = D[WIDTH-1] ? CC_N : ~|D ? CC_Z : CC_P;
  always_ff @(posedge Clk)
    if (Reset) cc <= CC_Z;
    else if (LD_CC) cc <= cc_next;
  assign NZP = cc;
endmodule

// File: tb/tb_lc3_regfile.sv
// tb_lc3_regfile: table-driven scoreboard bench for lc3_regfile (DEPTH=8 and DEPTH=6 instances).
module tb_lc3_regfile;
  logic Clk = 0, Reset = 0, WE = 0, LD_CC = 0;
  logic [2:0] DR = 0, SR1 = 0, SR2 = 0;
  logic [15:0] D = 0;
  logic [15:0] o1, o2, p1, p2;
  logic [2:0] nzp, nzp6;
  int total = 0, bad = 0;

  always #5 Clk = ~Clk;

  lc3_regfile u_dut (
    .Clk(Clk), .Reset(Reset), .WE(WE), .DR(DR), .D(D), .LD_CC(LD_CC),
    .SR1(SR1), .SR2(SR2), .SR1_out(o1), .SR2_out(o2), .NZP(nzp)
  );
  lc3_regfile #(.DEPTH(6)) u_dut6 (
    .Clk(Clk), .Reset(Reset), .WE(WE), .DR(DR), .D(D), .LD_CC(LD_CC),
    .SR1(SR1), .SR2(SR2), .SR1_out(p1), .SR2_out(p2), .NZP(nzp6)
  );

  typedef struct {
    logic rst, we;
    logic [2:0] dr;
    logic [15:0] d;
    logic ld;
    logic [2:0] sr1, sr2;
    logic [15:0] e1, e2;
    logic [2:0] enzp;
  } vec_t;
  typedef struct {
    int idx;
    logic [15:0] e1, e2;
    logic [2:0] enzp;
  } exp_t;

  vec_t vecs [13];
  exp_t sb [$];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rst, we, input logic [2:0] dr, input logic [15:0] d,
                       input logic ld, input logic [2:0] sr1, sr2);
    Reset = rst; WE = we; DR = dr; D = d; LD_CC = ld; SR1 = sr1; SR2 = sr2;
  endtask

  task automatic pop_check();
    exp_t e;
    if (sb.size() == 0) begin
      total++; bad++;
      $display("FAIL scoreboard: got empty queue expected entry");
    end else begin
      e = sb.pop_front();
      chk($sformatf("vec%0d sr1", e.idx), o1, e.e1);
      chk($sformatf("vec%0d sr2", e.idx), o2, e.e2);
      chk($sformatf("vec%0d nzp", e.idx), 16'(nzp), 16'(e.enzp));
    end
  endtask

  initial begin
    //          rst we dr  d         ld sr1 sr2 e1        e2        nzp
    vecs[0]  = '{1, 0, 0, 16'h0000, 0, 0, 7, 16'h0000, 16'h0000, 3'b010};
    vecs[1]  = '{0, 1, 3, 16'hBEEF, 0, 3, 3, 16'hBEEF, 16'hBEEF, 3'b010};
    vecs[2]  = '{0, 0, 0, 16'h0000, 0, 3, 4, 16'hBEEF, 16'h0000, 3'b010};
    vecs[3]  = '{0, 1, 5, 16'h1234, 0, 5, 3, 16'h1234, 16'hBEEF, 3'b010};
    vecs[4]  = '{0, 0, 0, 16'h8000, 1, 5, 3, 16'h1234, 16'hBEEF, 3'b100};
    vecs[5]  = '{0, 0, 0, 16'h0000, 1, 5, 3, 16'h1234, 16'hBEEF, 3'b010};
    vecs[6]  = '{0, 0, 0, 16'h0001, 1, 5, 3, 16'h1234, 16'hBEEF, 3'b001};
    vecs[7]  = '{0, 1, 1, 16'h7FFF, 1, 1, 5, 16'h7FFF, 16'h1234, 3'b001};
    vecs[8]  = '{0, 1, 0, 16'h8001, 1, 0, 1, 16'h8001, 16'h7FFF, 3'b100};
    vecs[9]  = '{0, 1, 7, 16'h5555, 0, 7, 0, 16'h5555, 16'h8001, 3'b100};
    vecs[10] = '{1, 1, 2, 16'hFFFF, 1, 2, 7, 16'h0000, 16'h0000, 3'b010};
    vecs[11] = '{0, 0, 0, 16'h0000, 0, 2, 3, 16'h0000, 16'h0000, 3'b010};
    vecs[12] = '{0, 0, 0, 16'h0400, 1, 3, 7, 16'h0000, 16'h0000, 3'b001};

    // Each vector's expectation is checked at the negedge after its edge.
    for (int k = 0; k < 13; k++) begin
      @(negedge Clk);
      if (k > 0) pop_check();
      drive(vecs[k].rst, vecs[k].we, vecs[k].dr, vecs[k].d, vecs[k].ld, vecs[k].sr1, vecs[k].sr2);
      sb.push_back('{k, vecs[k].e1, vecs[k].e2, vecs[k].enzp});
    end
    @(negedge Clk);
    pop_check();

    // Reset sweep across both read ports
    drive(1, 0, 0, 16'h0, 0, 0, 0);
    @(negedge Clk);
    drive(0, 0, 0, 16'h0, 0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      SR1 = 3'(i); SR2 = 3'(7 - i);
      #1;
      chk($sformatf("rst sweep sr1=%0d", i), o1, 16'h0000);
      chk($sformatf("rst sweep sr2=%0d", 7 - i), o2, 16'h0000);
    end
    chk("rst nzp", 16'(nzp), 16'h0002);

    // Same-cycle read of the register being written
    @(negedge Clk);
    drive(0, 1, 5, 16'h1234, 0, 5, 0);
    #1;
`ifdef REGFILE_BYPASS_EN
    chk("same-cycle r5", o1, 16'h1234);
`else
    chk("same-cycle r5", o1, 16'h0000);
`endif
    @(posedge Clk); #1;
    chk("after-edge r5", o1, 16'h1234);
    @(negedge Clk);
    WE = 0;
    #1;
    chk("held r5", o1, 16'h1234);

    // Reset wins over a write and blocks forwarding
    @(negedge Clk);
    drive(0, 1, 4, 16'h4444, 0, 4, 4);
    @(negedge Clk);
    drive(1, 1, 4, 16'h9999, 1, 4, 5);
    #1;
    chk("rst-cycle read r4", o1, 16'h4444);
    chk("rst-cycle read r5", o2, 16'h1234);
    @(posedge Clk); #1;
    chk("post-rst r4", o1, 16'h0000);
    chk("post-rst r5", o2, 16'h0000);
    chk("post-rst nzp", 16'(nzp), 16'h0002);

    // DEPTH=6: out-of-range write dropped, out-of-range read is zero
    @(negedge Clk);
    drive(0, 1, 7, 16'hAAAA, 0, 7, 5);
    #1;
    chk("d6 same-cycle sr1=7", p1, 16'h0000);
    @(negedge Clk);
    WE = 0;
    for (int i = 0; i < 8; i++) begin
      SR1 = 3'(i);
      #1;
      chk($sformatf("d6 r%0d", i), p1, 16'h0000);
      chk($sformatf("d8 r%0d", i), o1, (i == 7) ? 16'hAAAA : 16'h0000);
    end
    @(negedge Clk);
    drive(0, 1, 5, 16'h5A5A, 0, 0, 0);
    @(negedge Clk);
    drive(0, 0, 0, 16'h0, 0, 5, 5);
    #1;
    chk("d6 r5 write", p1, 16'h5A5A);
    chk("d6 r5 port2", p2, 16'h5A5A);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
